pipeline_control_unit: RTL and testbench
========================================

# pipeline_control_unit

Central stall/flush sequencer for the 5-stage pipeline. Combines the combinational load-use hazard flag, ID-stage branch resolution and a variable-latency data-memory handshake into per-stage register write-enables, flushes and bubbles. Each control output is a function of the current state and this cycle's inputs, so a memory hit costs zero cycles. The block also keeps a saturating stall-cycle counter and a sticky memory-timeout error.

## Interface
- MEM_TIMEOUT, 255: maximum MEM_WAIT cycles before the ERROR state; legal range 1..2^WAIT_W-1.
- WAIT_W, 8: width of the wait counter.
- STALL_CNT_W, 16: width of the stall-cycle counter.

- clk_i  in  1  sole clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- start_i  in  1  pipeline enable.
- hazard_i  in  1  load-use hazard from hazard detection; combinational, same cycle.
- branch_taken_i  in  1  branch in ID resolved taken.
- mem_req_i  in  1  the instruction in MEM is a load or store.
- mem_ready_i  in  1  memory completes the access this cycle.
- pc_write_o  out  1  PC write-enable.
- if_id_write_o  out  1  IF/ID write-enable.
- if_id_flush_o  out  1  IF/ID loads a NOP.
- id_ex_bubble_o  out  1  ID/EX loads a NOP (control bits cleared).
- id_ex_write_o  out  1  ID/EX write-enable.
- ex_mem_write_o  out  1  EX/MEM write-enable.
- mem_wb_bubble_o  out  1  MEM/WB loads a NOP.
- stall_cycles_o  out  STALL_CNT_W  saturating count of stalled cycles.
- timeout_o  out  1  sticky memory-timeout error.

## Operation
- States: IDLE, RUN, MEM_WAIT, ERROR.
- Reset value: state IDLE, both counters 0, timeout_o 0.

Frozen outputs (IDLE, ERROR):
- All write-enables 0; all flush/bubble outputs 0.

RUN outputs, first matching rule applies:
1. mem_req_i & !mem_ready_i (memory stall):
   - all write-enables 0; mem_wb_bubble_o 1.
   - hazard_i and branch_taken_i are ignored.
   - Next state MEM_WAIT.
2. hazard_i (load-use):
   - pc_write_o 0, if_id_write_o 0, id_ex_bubble_o 1.
   - EX/MEM and ID/EX write-enables 1; branch_taken_i is ignored.
3. branch_taken_i:
   - All write-enables 1; if_id_flush_o 1.
4. Otherwise: all write-enables 1; flush and bubble outputs 0.

MEM_WAIT:
- While mem_ready_i is 0: outputs as rule 1, wait counter +1.
- On mem_ready_i 1: RUN rules 2-4 are evaluated this same cycle; next state RUN; wait counter cleared.
- If the wait counter reaches MEM_TIMEOUT with mem_ready_i still 0: next state ERROR.

ERROR:
- timeout_o 1; stays in ERROR until rst_i.

Transitions:
- IDLE -> RUN when start_i is 1.
- RUN -> IDLE when start_i is 0 and rule 1 is not active.
- start_i 0 during MEM_WAIT has no effect until the transaction completes; the block then returns to RUN, then IDLE on the next edge if start_i is still 0.

stall_cycles_o:
- Increments on each cycle in RUN or MEM_WAIT with pc_write_o 0.
- Saturates at 2^STALL_CNT_W-1.
- Flushes are not counted.

## Timing
- All control outputs are combinational from state and inputs; no input-to-output register.
- Load-use stall lasts exactly one cycle. The frozen pipeline re-evaluates hazard_i the next cycle, and the upstream unit deasserts it.
- A memory access with ready in the request cycle costs 0 cycles.
- A memory access whose ready arrives N cycles after the request cycle freezes the pipeline for N cycles.
- Branch flush costs 1 cycle.
- Load-use together with a taken branch: stall first; the branch is flushed on the following cycle.
- Asynchronous reset mid-MEM_WAIT: outputs go to IDLE values immediately and counters clear. No memory transaction is tracked afterwards.
- Counters and state update on the rising edge of clk_i.

## Structure
- Package pipeline_ctrl_pkg holds:
  - the state enum (IDLE, RUN, MEM_WAIT, ERROR);
  - default values of MEM_TIMEOUT, WAIT_W and STALL_CNT_W;
  - a constant for the "all stages advance" output vector.
- Sub-module sat_counter (parameter width; inputs clear, inc; output count) is instantiated twice: once as the wait counter, once as the stall counter.

## Test plan
- Reset, then start_i 1 with no events: one cycle after start_i, all write-enables 1, flush/bubble 0, stall_cycles_o 0.
- hazard_i 1 for one cycle in RUN: that cycle pc_write_o 0, if_id_write_o 0, id_ex_bubble_o 1; stall_cycles_o becomes 1.
- mem_req_i 1 with mem_ready_i arriving 3 cycles later: write-enables 0 for 3 cycles, advance in the 4th cycle; stall_cycles_o +3; state back to RUN.
- hazard_i, branch_taken_i and mem_req_i all 1 with mem_ready_i 0: memory freeze only, no flush. When ready arrives with hazard_i 1: bubble that cycle, flush the next cycle.
- MEM_TIMEOUT=4 with mem_ready_i never asserted: ERROR entered, timeout_o 1, all enables 0, held until rst_i 0; rst_i clears timeout_o asynchronously.
- STALL_CNT_W=4 with 20 load-use stalls: stall_cycles_o saturates at 15.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// Control bundle order: pc, if_id write/flush, id_ex bubble/write, ex_mem, mem_wb.
package pipeline_ctrl_pkg;

  localparam int MEM_TIMEOUT_DEF = 255;
  localparam int WAIT_W_DEF      = 8;
  localparam int STALL_CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_ERROR    = 2'd3
  } state_e;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_bubble;
    logic id_ex_write;
    logic ex_mem_write;
    logic mem_wb_bubble;
  } ctrl_t;

  localparam ctrl_t CTRL_ADVANCE = '{
    pc_write:     1'b1,
    if_id_write:  1'b1,
    if_id_flush:  1'b0,
    id_ex_bubble: 1'b0,
    id_ex_write:  1'b1,
    ex_mem_write: 1'b1,
    mem_wb_bubble: 1'b0
  };

  localparam ctrl_t CTRL_HOLD = '0;

  localparam ctrl_t CTRL_MEM_FREEZE = '{
    pc_write:     1'b0,
    if_id_write:  1'b0,
    if_id_flush:  1'b0,
    id_ex_bubble: 1'b0,
    id_ex_write:  1'b0,
    ex_mem_write: 1'b0,
    mem_wb_bubble: 1'b1
  };

  localparam ctrl_t CTRL_LOAD_USE = '{
    pc_write:     1'b0,
    if_id_write:  1'b0,
    if_id_flush:  1'b0,
    id_ex_bubble: 1'b1,
    id_ex_write:  1'b1,
    ex_mem_write: 1'b1,
    mem_wb_bubble: 1'b0
  };

  localparam ctrl_t CTRL_BRANCH = '{
    pc_write:     1'b1,
    if_id_write:  1'b1,
    if_id_flush:  1'b1,
    id_ex_bubble: 1'b0,
    id_ex_write:  1'b1,
    ex_mem_write: 1'b1,
    mem_wb_bubble: 1'b0
  };

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over inc).
// Holds at all-ones once reached.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clear_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] r_count;
  logic         w_full;

  assign w_full  = &r_count;
  assign count_o = r_count;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_count <= '0;
    end else if (clear_i) begin
      r_count <= '0;
    end else if (inc_i && !w_full) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_control_unit.sv
// Stall/flush sequencer: load-use, ID branch flush and memory wait states.
// Outputs are combinational from state and inputs so a memory hit is free.
module pipeline_control_unit
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int WAIT_W      = WAIT_W_DEF,
  parameter int STALL_CNT_W = STALL_CNT_W_DEF
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic                   hazard_i,
  input  logic                   branch_taken_i,
  input  logic                   mem_req_i,
  input  logic                   mem_ready_i,
  output logic                   pc_write_o,
  output logic                   if_id_write_o,
  output logic                   if_id_flush_o,
  output logic                   id_ex_bubble_o,
  output logic                   id_ex_write_o,
  output logic                   ex_mem_write_o,
  output logic                   mem_wb_bubble_o,
  output logic [STALL_CNT_W-1:0] stall_cycles_o,
  output logic                   timeout_o
);

  localparam logic [WAIT_W-1:0] TO_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_e           r_state;
  state_e           w_next;
  ctrl_t            w_ctrl;
  logic             w_active;
  logic             w_mem_stall;
  logic             w_wait_inc;
  logic             w_stall_inc;
  logic [WAIT_W-1:0] w_wait_cnt;

  assign w_active = (r_state == ST_RUN) || (r_state == ST_MEM_WAIT);

  // MEM_WAIT keeps freezing until ready, regardless of mem_req_i
  assign w_mem_stall =
    ((r_state == ST_RUN) && mem_req_i && !mem_ready_i) ||
    ((r_state == ST_MEM_WAIT) && !mem_ready_i);

  assign w_wait_inc  = (r_state == ST_MEM_WAIT) && !mem_ready_i;
  assign w_stall_inc = w_active && !w_ctrl.pc_write;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (start_i) w_next = ST_RUN;
      end
      ST_RUN: begin
        if (w_mem_stall)   w_next = ST_MEM_WAIT;
        else if (!start_i) w_next = ST_IDLE;
      end
      ST_MEM_WAIT: begin
        if (mem_ready_i)              w_next = ST_RUN;
        else if (w_wait_cnt == TO_LAST) w_next = ST_ERROR;
      end
      ST_ERROR: w_next = ST_ERROR;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_ctrl = CTRL_HOLD;
    if (w_active) begin
      if (w_mem_stall)         w_ctrl = CTRL_MEM_FREEZE;
      else if (hazard_i)       w_ctrl = CTRL_LOAD_USE;
      else if (branch_taken_i) w_ctrl = CTRL_BRANCH;
      else                     w_ctrl = CTRL_ADVANCE;
    end
  end

  assign pc_write_o      = w_ctrl.pc_write;
  assign if_id_write_o   = w_ctrl.if_id_write;
  assign if_id_flush_o   = w_ctrl.if_id_flush;
  assign id_ex_bubble_o  = w_ctrl.id_ex_bubble;
  assign id_ex_write_o   = w_ctrl.id_ex_write;
  assign ex_mem_write_o  = w_ctrl.ex_mem_write;
  assign mem_wb_bubble_o = w_ctrl.mem_wb_bubble;
  assign timeout_o       = (r_state == ST_ERROR);

  sat_counter #(.W(WAIT_W)) u_wait_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (!w_wait_inc),
    .inc_i   (w_wait_inc),
    .count_o (w_wait_cnt)
  );

  sat_counter #(.W(STALL_CNT_W)) u_stall_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (1'b0),
    .inc_i   (w_stall_inc),
    .count_o (stall_cycles_o)
  );

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Directed bench: default instance plus MEM_TIMEOUT=4 / STALL_CNT_W=4 instance.
module tb_pipeline_control_unit;

  localparam logic [6:0] FRZ  = 7'b0000000;
  localparam logic [6:0] MEMF = 7'b0000001;
  localparam logic [6:0] ADV  = 7'b1100110;
  localparam logic [6:0] LU   = 7'b0001110;
  localparam logic [6:0] BR   = 7'b1110110;

  logic clk = 1'b0;
  logic rst_i, start_i, hazard_i, branch_taken_i, mem_req_i, mem_ready_i;

  logic a_pc, a_ifw, a_iff, a_bub, a_idw, a_exw, a_mwb, a_to;
  logic b_pc, b_ifw, b_iff, b_bub, b_idw, b_exw, b_mwb, b_to;
  logic [15:0] a_stall;
  logic [3:0]  b_stall;
  logic [6:0]  out_a, out_b;

  int checks = 0;
  int failures = 0;
  int exp_stall = 0;

  assign out_a = {a_pc, a_ifw, a_iff, a_bub, a_idw, a_exw, a_mwb};
  assign out_b = {b_pc, b_ifw, b_iff, b_bub, b_idw, b_exw, b_mwb};

  always #5 clk = ~clk;

  pipeline_control_unit u_dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .hazard_i(hazard_i),
    .branch_taken_i(branch_taken_i), .mem_req_i(mem_req_i),
    .mem_ready_i(mem_ready_i), .pc_write_o(a_pc), .if_id_write_o(a_ifw),
    .if_id_flush_o(a_iff), .id_ex_bubble_o(a_bub), .id_ex_write_o(a_idw),
    .ex_mem_write_o(a_exw), .mem_wb_bubble_o(a_mwb),
    .stall_cycles_o(a_stall), .timeout_o(a_to)
  );

  pipeline_control_unit #(.MEM_TIMEOUT(4), .STALL_CNT_W(4)) u_small (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .hazard_i(hazard_i),
    .branch_taken_i(branch_taken_i), .mem_req_i(mem_req_i),
    .mem_ready_i(mem_ready_i), .pc_write_o(b_pc), .if_id_write_o(b_ifw),
    .if_id_flush_o(b_iff), .id_ex_bubble_o(b_bub), .id_ex_write_o(b_idw),
    .ex_mem_write_o(b_exw), .mem_wb_bubble_o(b_mwb),
    .stall_cycles_o(b_stall), .timeout_o(b_to)
  );

  task automatic cyc(input logic s, h, b, q, r);
    @(negedge clk);
    start_i = s; hazard_i = h; branch_taken_i = b;
    mem_req_i = q; mem_ready_i = r;
    #1;
  endtask

  task automatic test_reset;
    rst_i = 1'b0;
    cyc(1, 1, 1, 1, 0);
    checks++;
    if (out_a !== FRZ || out_b !== FRZ) begin
      failures++;
      $display("FAIL reset_out a=%b b=%b exp=%b", out_a, out_b, FRZ);
    end
    checks++;
    if (a_stall !== 16'd0 || b_stall !== 4'd0 || a_to !== 1'b0 || b_to !== 1'b0) begin
      failures++;
      $display("FAIL reset_cnt stall=%0d/%0d to=%b/%b exp 0", a_stall, b_stall, a_to, b_to);
    end
    cyc(0, 0, 0, 0, 0);
    rst_i = 1'b1;
    exp_stall = 0;
  endtask

  task automatic test_start;
    cyc(1, 0, 0, 0, 0);
    checks++;
    if (out_a !== FRZ) begin
      failures++;
      $display("FAIL start_idle got=%b exp=%b", out_a, FRZ);
    end
    cyc(1, 0, 0, 0, 0);
    checks++;
    if (out_a !== ADV || a_stall !== 16'(exp_stall)) begin
      failures++;
      $display("FAIL start_run got=%b stall=%0d exp=%b stall=%0d", out_a, a_stall, ADV, exp_stall);
    end
  endtask

  task automatic test_hazard;
    cyc(1, 1, 0, 0, 0);
    checks++;
    if (out_a !== LU) begin
      failures++;
      $display("FAIL hazard_out got=%b exp=%b", out_a, LU);
    end
    exp_stall += 1;
    cyc(1, 0, 0, 0, 0);
    checks++;
    if (out_a !== ADV || a_stall !== 16'(exp_stall)) begin
      failures++;
      $display("FAIL hazard_after got=%b stall=%0d exp=%b stall=%0d", out_a, a_stall, ADV, exp_stall);
    end
  endtask

  task automatic test_mem_wait;
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 1, 0);
      checks++;
      if (out_a !== MEMF) begin
        failures++;
        $display("FAIL mem_freeze%0d got=%b exp=%b", i, out_a, MEMF);
      end
    end
    cyc(1, 0, 0, 1, 1);
    checks++;
    if (out_a !== ADV) begin
      failures++;
      $display("FAIL mem_ready got=%b exp=%b", out_a, ADV);
    end
    exp_stall += 3;
    cyc(1, 0, 0, 0, 0);
    checks++;
    if (out_a !== ADV || a_stall !== 16'(exp_stall)) begin
      failures++;
      $display("FAIL mem_back_run got=%b stall=%0d exp=%b stall=%0d", out_a, a_stall, ADV, exp_stall);
    end
  endtask

  task automatic test_idle_return;
    cyc(1, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    checks++;
    if (out_a !== MEMF) begin
      failures++;
      $display("FAIL wait_ignores_start got=%b exp=%b", out_a, MEMF);
    end
    cyc(0, 0, 0, 1, 1);
    checks++;
    if (out_a !== ADV) begin
      failures++;
      $display("FAIL wait_done got=%b exp=%b", out_a, ADV);
    end
    cyc(0, 0, 0, 0, 0);
    checks++;
    if (out_a !== ADV) begin
      failures++;
      $display("FAIL run_before_idle got=%b exp=%b", out_a, ADV);
    end
    exp_stall += 2;
    cyc(0, 0, 0, 0, 0);
    checks++;
    if (out_a !== FRZ || a_stall !== 16'(exp_stall)) begin
      failures++;
      $display("FAIL back_idle got=%b stall=%0d exp=%b stall=%0d", out_a, a_stall, FRZ, exp_stall);
    end
    test_start();
  endtask

  task automatic test_combo;
    cyc(1, 1, 1, 1, 0);
    checks++;
    if (out_a !== MEMF) begin
      failures++;
      $display("FAIL combo_req got=%b exp=%b", out_a, MEMF);
    end
    cyc(1, 1, 1, 1, 0);
    checks++;
    if (out_a !== MEMF) begin
      failures++;
      $display("FAIL combo_wait got=%b exp=%b", out_a, MEMF);
    end
    cyc(1, 1, 1, 1, 1);
    checks++;
    if (out_a !== LU) begin
      failures++;
      $display("FAIL combo_ready_bubble got=%b exp=%b", out_a, LU);
    end
    cyc(1, 0, 1, 0, 0);
    checks++;
    if (out_a !== BR) begin
      failures++;
      $display("FAIL combo_flush got=%b exp=%b", out_a, BR);
    end
    exp_stall += 3;
    cyc(1, 0, 0, 0, 0);
    checks++;
    if (out_a !== ADV || a_stall !== 16'(exp_stall)) begin
      failures++;
      $display("FAIL combo_end got=%b stall=%0d exp=%b stall=%0d", out_a, a_stall, ADV, exp_stall);
    end
  endtask

  task automatic test_timeout;
    test_reset();
    test_start();
    cyc(1, 0, 0, 1, 0);
    for (int i = 1; i <= 4; i++) begin
      cyc(1, 0, 0, 1, 0);
      checks++;
      if (out_b !== MEMF || b_to !== 1'b0) begin
        failures++;
        $display("FAIL to_wait%0d got=%b to=%b exp=%b to=0", i, out_b, b_to, MEMF);
      end
    end
    cyc(1, 0, 0, 1, 0);
    checks++;
    if (out_b !== FRZ || b_to !== 1'b1) begin
      failures++;
      $display("FAIL to_error got=%b to=%b exp=%b to=1", out_b, b_to, FRZ);
    end
    checks++;
    if (out_a !== MEMF || a_to !== 1'b0) begin
      failures++;
      $display("FAIL to_dflt_wait got=%b to=%b exp=%b to=0", out_a, a_to, MEMF);
    end
    cyc(1, 0, 0, 1, 1);
    checks++;
    if (out_a !== ADV || out_b !== FRZ || b_to !== 1'b1) begin
      failures++;
      $display("FAIL to_ready a=%b b=%b to=%b exp a=%b b=%b to=1", out_a, out_b, b_to, ADV, FRZ);
    end
    cyc(1, 0, 0, 1, 0);
    checks++;
    if (b_stall !== 4'd5 || a_stall !== 16'd6 || b_to !== 1'b1) begin
      failures++;
      $display("FAIL to_stall got=%0d/%0d to=%b exp=6/5 to=1", a_stall, b_stall, b_to);
    end
    cyc(1, 0, 0, 1, 0);
    #2;
    rst_i = 1'b0;
    #1;
    checks++;
    if (out_a !== FRZ || out_b !== FRZ || b_to !== 1'b0) begin
      failures++;
      $display("FAIL async_rst_out a=%b b=%b to=%b exp=%b to=0", out_a, out_b, b_to, FRZ);
    end
    checks++;
    if (a_stall !== 16'd0 || b_stall !== 4'd0) begin
      failures++;
      $display("FAIL async_rst_cnt got=%0d/%0d exp=0/0", a_stall, b_stall);
    end
    cyc(0, 0, 0, 0, 0);
    rst_i = 1'b1;
    exp_stall = 0;
  endtask

  task automatic test_saturation;
    test_reset();
    test_start();
    for (int i = 0; i < 20; i++) begin
      cyc(1, 1, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
    end
    checks++;
    if (b_stall !== 4'd15) begin
      failures++;
      $display("FAIL sat_small got=%0d exp=15", b_stall);
    end
    checks++;
    if (a_stall !== 16'd20 || out_a !== ADV) begin
      failures++;
      $display("FAIL sat_wide got=%0d out=%b exp=20 out=%b", a_stall, out_a, ADV);
    end
  endtask

  initial begin
    rst_i = 1'b0;
    start_i = 1'b0; hazard_i = 1'b0; branch_taken_i = 1'b0;
    mem_req_i = 1'b0; mem_ready_i = 1'b0;
    test_reset();
    test_start();
    test_hazard();
    test_mem_wait();
    test_idle_return();
    test_combo();
    test_timeout();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
